// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the unified memory bus arbiter: FSM encodings,
// default limits and the latched bus transaction record.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam int STARVE_LIM_DEF = 3;
  localparam int TIMEOUT_DEF    = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_xact_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the load/store
// unit; one transaction at a time, with starvation guard and hung-bus timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [3:0] SLIM  = 4'(STARVE_LIM);
  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  arb_state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;
  bus_xact_t  xact;
  logic       busy, ack, tmo, fin, grant_i, grant_d;

  assign busy = (state != ARB_IDLE);
  assign ack  = busy & bus_ack;
  // an ack arriving in the last allowed cycle still counts as a clean completion
  assign tmo  = busy & ~bus_ack & (wait_cnt == WLAST);
  assign fin  = ack | tmo;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_req && (!d_req || starve_cnt == SLIM)) begin
          grant_i   = 1'b1;
          state_nxt = ARB_BUSY_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = ARB_BUSY_D;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: if (fin) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      bus_req    <= 1'b0;
      xact       <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        bus_req    <= 1'b1;
        xact       <= '{we: 1'b0, addr: if_addr, wdata: 32'h0, wstrb: 4'h0};
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end else if (grant_d) begin
        bus_req  <= 1'b1;
        xact     <= '{we: d_we, addr: d_addr, wdata: d_wdata,
                      wstrb: (d_we ? d_wstrb : 4'h0)};
        wait_cnt <= '0;
        if (if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else if (busy) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (fin) bus_req <= 1'b0;
      end
    end
  end

  assign bus_we    = xact.we;
  assign bus_addr  = xact.addr;
  assign bus_wdata = xact.wdata;
  assign bus_wstrb = xact.wstrb;

  assign if_done  = (state == ARB_BUSY_I) & fin;
  assign d_done   = (state == ARB_BUSY_D) & fin;
  assign bus_err  = tmo;
  assign if_rdata = ((state == ARB_BUSY_I) && ack) ? bus_rdata : 32'h0;
  assign d_rdata  = ((state == ARB_BUSY_D) && ack) ? bus_rdata : 32'h0;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a transaction-level model
// predicts grants and completions; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;

  localparam int SLIM = 3;
  localparam int TMO  = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, bus_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        if_done, d_done, bus_err, bus_req, bus_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  mem_bus_arbiter #(.STARVE_LIM(SLIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit is_d; logic we; logic [31:0] addr, wdata; logic [3:0] wstrb; } bus_exp_t;
  typedef struct { int cyc; bit is_d; logic [31:0] rdata; bit err; } done_exp_t;

  bus_exp_t  bq[$];
  done_exp_t dq[$];
  int checks = 0, errors = 0, cyc = 0;
  bit e_stall_if, e_stall_mem, e_bus_req;

  // transaction-level model state
  int owner = 0, age = 0, lat = 0, starve = 0, force_lat = 0;
  bit if_pend = 0, d_pend = 0, gen_en = 0, hold_all = 0;
  logic [31:0] ia, da, dw;
  logic        dwe;
  logic [3:0]  ds;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat != 0) return force_lat;
    r = $urandom_range(0, 24);
    if (r == 0) return TMO;
    if (r == 1) return TMO + 1 + $urandom_range(0, 5);
    if (r == 2) return TMO - 1;
    return $urandom_range(1, 4);
  endfunction

  // One clock of stimulus plus model prediction for that cycle.
  task automatic step();
    logic [31:0] rd;
    bit done, ackd;
    @(posedge clk); #1; cyc++;
    if (gen_en) begin
      if (!if_pend && (hold_all || $urandom_range(0, 2) == 0)) begin
        if_pend = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && (hold_all || $urandom_range(0, 2) == 0)) begin
        d_pend = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom); ds = 4'($urandom);
      end
    end
    if_req  = if_pend;
    d_req   = d_pend;
    // owner's request fields churn while busy; the latched bus must not follow
    if_addr = (owner == 1) ? $urandom : ia;
    d_addr  = (owner == 2) ? $urandom : da;
    d_wdata = (owner == 2) ? $urandom : dw;
    d_we    = (owner == 2) ? 1'($urandom) : dwe;
    d_wstrb = (owner == 2) ? 4'($urandom) : ds;
    rd = $urandom;
    bus_rdata = rd;
    if (owner == 0) begin
      bus_ack = ($urandom_range(0, 7) == 0);
      e_bus_req = 0; e_stall_if = if_pend; e_stall_mem = d_pend;
      if (if_pend && (!d_pend || starve == SLIM)) begin
        bq.push_back('{cyc + 1, 1'b0, 1'b0, ia, 32'h0, 4'h0});
        starve = 0; owner = 1; age = 0; lat = pick_lat();
      end else if (d_pend) begin
        bq.push_back('{cyc + 1, 1'b1, dwe, da, dw, (dwe ? ds : 4'h0)});
        if (if_pend && starve < 15) starve++;
        owner = 2; age = 0; lat = pick_lat();
      end
    end else begin
      age++;
      ackd = (age == lat);
      done = ackd || (age == TMO);
      bus_ack = ackd;
      e_bus_req   = 1;
      e_stall_if  = if_pend && !(done && owner == 1);
      e_stall_mem = d_pend && !(done && owner == 2);
      if (done) begin
        dq.push_back('{cyc, (owner == 2), (ackd ? rd : 32'h0), !ackd});
        if (owner == 1) if_pend = 0; else d_pend = 0;
        owner = 0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    gen_en = 0; hold_all = 0;
    while ((owner != 0 || if_pend || d_pend) && n < 400) begin step(); n++; end
    chk("drain_bound", 32'(n < 400), 32'd1);
    step();
  endtask

  // monitor: compares DUT outputs against model expectations at negedge
  initial begin : monitor
    bus_exp_t  cur;
    done_exp_t e;
    bit prev_req = 0;
    cur = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    forever begin
      @(negedge clk);
      if (!rst_n || cyc == 0) begin
        prev_req = 0;
      end else begin
        chk("stall_if", 32'(stall_if), 32'(e_stall_if));
        chk("stall_mem", 32'(stall_mem), 32'(e_stall_mem));
        chk("bus_req", 32'(bus_req), 32'(e_bus_req));
        if (bus_req && !prev_req) begin
          if (bq.size() == 0) begin
            errors++; checks++;
            $display("FAIL bus_grant: got unexpected bus_req rise expected none (cycle %0d)", cyc);
          end else begin
            cur = bq.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(cur.cyc));
          end
        end
        if (bus_req) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
          if (cur.is_d) chk("bus_wdata", bus_wdata, cur.wdata);
        end
        prev_req = bus_req;
        if (if_done || d_done) begin
          if (dq.size() == 0) begin
            errors++; checks++;
            $display("FAIL done: got if_done=%0b d_done=%0b expected none (cycle %0d)", if_done, d_done, cyc);
          end else begin
            e = dq.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("if_done", 32'(if_done), 32'(!e.is_d));
            chk("d_done", 32'(d_done), 32'(e.is_d));
            chk("bus_err", 32'(bus_err), 32'(e.err));
            chk("if_rdata", if_rdata, e.is_d ? 32'h0 : e.rdata);
            chk("d_rdata", d_rdata, e.is_d ? e.rdata : 32'h0);
          end
        end else begin
          chk("idle_err", 32'(bus_err), 32'd0);
          chk("idle_if_rdata", if_rdata, 32'h0);
          chk("idle_d_rdata", d_rdata, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset state, with requests and ack asserted to show they are held off
    if_req = 1; d_req = 1; bus_ack = 1;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_done", 32'({if_done, d_done, bus_err}), 32'd0);
    if_req = 0; d_req = 0; bus_ack = 0;
    e_bus_req = 0; e_stall_if = 0; e_stall_mem = 0;
    @(posedge clk); #2; rst_n = 1;

    // continuous contention with short latency exercises the starvation guard
    gen_en = 1; hold_all = 1; force_lat = 2;
    repeat (80) step();
    drain();
    force_lat = 0;

    gen_en = 1;
    repeat (2500) step();
    drain();

    // reset in the middle of an IF transaction
    if_pend = 1; ia = 32'h100; force_lat = 1000;
    step();
    step();
    @(negedge clk); #2;
    rst_n = 0; #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_if_done", 32'(if_done), 32'd0);
    owner = 0; if_pend = 0; d_pend = 0; starve = 0; force_lat = 0;
    if_req = 0; d_req = 0; bus_ack = 0;
    e_bus_req = 0; e_stall_if = 0; e_stall_mem = 0;
    @(posedge clk); #2; rst_n = 1;
    chk("mid_rst_bus_req_post", 32'(bus_req), 32'd0);

    gen_en = 1; hold_all = 1; force_lat = 1;
    repeat (40) step();
    drain();
    force_lat = 0;
    gen_en = 1;
    repeat (2000) step();
    drain();

    @(negedge clk);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single unified memory bus between instruction fetch (IF port) and the MEM-stage load/store unit (D port) of the RV32 pipeline.
Grants one transaction at a time and latches its address, data, write enable and byte strobes into bus registers.
Waits for bus_ack, then returns a one-cycle done pulse with read data to the owner.
Produces stall_if and stall_mem for the pipeline hazard logic, and guards against a hung bus with a timeout.

Parameters:
STARVE_LIM, 3, consecutive D grants taken while if_req is high before IF is forced to win; range 1..15
TIMEOUT, 64, cycles in a BUSY state without bus_ack before the transaction is aborted; range 2..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  32  fetch address, word aligned
if_done  out  1  one-cycle completion pulse for IF
if_rdata  out  32  fetched word, valid while if_done=1
d_req  in  1  load/store request; held high until d_done
d_we  in  1  1 = store
d_addr  in  32  data address
d_wdata  in  32  store data
d_wstrb  in  4  byte enables for a store
d_done  out  1  one-cycle completion pulse for D
d_rdata  out  32  load word, valid while d_done=1
bus_err  out  1  qualifies if_done/d_done; 1 = transaction timed out
bus_req  out  1  bus valid, registered
bus_we  out  1  registered write enable
bus_addr  out  32  registered address
bus_wdata  out  32  registered write data
bus_wstrb  out  4  registered byte strobes; 4'h0 on reads
bus_ack  in  1  bus completion; bus_rdata valid in the same cycle
bus_rdata  in  32  read data
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  d_req & ~d_done

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state = IDLE.
  - bus_req, bus_we = 0; bus_addr, bus_wdata = 0; bus_wstrb = 0.
  - Starvation counter and wait counter = 0.
  - All done and err outputs = 0.
  - Reset in the middle of a transaction abandons it silently; no done pulse is issued.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated on each cycle:
  - Only d_req high: go to BUSY_D.
  - Only if_req high: go to BUSY_I.
  - Both high: BUSY_D, unless starve_cnt == STARVE_LIM, in which case BUSY_I.
  - On entry to either BUSY state: bus_* registers load the winner's request fields, bus_req is set to 1, and wait_cnt is cleared.
  - For an IF grant: bus_we = 0 and bus_wstrb = 0.
- Starvation counter (4 bits, saturating):
  - Increments on a D grant while if_req = 1.
  - Clears on any IF grant.
- BUSY_x:
  - bus_req is held high with fixed fields. Changes or drops on the requester side are ignored until completion.
  - wait_cnt increments every cycle.
  - bus_ack = 1 completes the transaction: x_done = 1 and x_rdata = bus_rdata in the same cycle (combinational), bus_err = 0. Next state is IDLE and bus_req = 0.
- Timeout:
  - Triggered when wait_cnt == TIMEOUT-1 with no ack.
  - In that cycle: x_done = 1, bus_err = 1, x_rdata = 0. Next state is IDLE.
- If bus_ack and the timeout fire in the same cycle, the ack wins and bus_err = 0.
- Latency:
  - A request seen in IDLE at cycle T gives bus_req = 1 at T+1.
  - Best-case done is at T+1 (bus_ack in the first BUSY cycle).
  - There is one mandatory IDLE cycle between transactions.
- In IDLE, and in any BUSY state for the non-owner: done and rdata outputs are 0.
- bus_ack while in IDLE is ignored.

Decomposition:
- Shared defines header, alongside the existing instruction IDs:
  - FSM state encodings (ARB_IDLE = 2'd0, ARB_BUSY_I = 2'd1, ARB_BUSY_D = 2'd2).
  - Default STARVE_LIM and TIMEOUT constants.
- Everything else stays in the one module; no sub-module is needed.

Test Plan:
- Single IF read: if_req=1, if_addr=0x100, bus_ack on the 2nd BUSY cycle with bus_rdata=0xDEADBEEF -> bus_req high for 2 cycles with bus_addr=0x100, bus_we=0; if_done=1 with if_rdata=0xDEADBEEF; stall_if high until then.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x55AA, d_wstrb=4'b0011, bus_ack immediate -> bus fields match the request; d_done at T+1; then one IDLE cycle.
- Contention and starvation (STARVE_LIM=3): if_req and d_req both held continuously -> grant order D,D,D,I,D,D,D,I...
- Timeout (TIMEOUT=64): D read with no ack -> d_done=1, bus_err=1, d_rdata=0 exactly 64 cycles after bus_req rose; bus_req=0 in the following cycle.
- Ack and timeout together: bus_ack in cycle 64 -> normal completion with bus_err=0.
- Reset mid-transaction: rst_n pulled low in BUSY_I -> bus_req=0 immediately (asynchronous); no if_done; after release, arbitration restarts from IDLE with starve_cnt=0.
